// File: rtl/fir_sample_source_if.sv
// Bundle of the sample-source buses: write side into the sample FIFO and the
// four-phase input_ready/output_ready handshake toward the filter.
interface fir_sample_source_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] in_sample;
  logic              input_ready;
  logic              output_ready;
  logic [DATA_W-1:0] filt_out;
  logic [DATA_W-1:0] last_result;
  logic              sample_done;
  logic              overflow;
  logic              timeout_err;

  modport master (
    output wr_en, wr_data, output_ready, filt_out,
    input  full, empty, count, in_sample, input_ready, last_result,
           sample_done, overflow, timeout_err
  );

  modport slave (
    input  wr_en, wr_data, output_ready, filt_out,
    output full, empty, count, in_sample, input_ready, last_result,
           sample_done, overflow, timeout_err
  );
endinterface

// File: rtl/fir_sample_source.sv
// Sample FIFO feeding a filter over a four-phase input_ready/output_ready handshake.
// Optional handshake abort timer enabled by defining FIR_SRC_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no sample outstanding; pops FIFO head when non-empty
// SEND     | sample presented (input_ready=1 one cycle after pop), awaiting output_ready
// WAIT_REL | result captured, waiting for output_ready to drop
module fir_sample_source #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_05,
  input  logic              rst,
  fir_sample_source_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_REL} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              pop, push, is_full;
  logic              pend;
  logic [DATA_W-1:0] in_sample, last_result;
  logic              input_ready, sample_done, overflow;

  assign is_full = (cnt == CW'(DEPTH));
  assign pop     = (state == IDLE) && (cnt != '0);
  assign push    = bus.wr_en && (!is_full || pop);

  assign bus.full        = is_full;
  assign bus.empty       = (cnt == '0);
  assign bus.count       = cnt;
  assign bus.in_sample   = in_sample;
  assign bus.input_ready = input_ready;
  assign bus.last_result = last_result;
  assign bus.sample_done = sample_done;
  assign bus.overflow    = overflow;

  // Storage is not reset; occupancy is tracked solely by the pointers and cnt.
  always_ff @(posedge clk_05) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk_05 or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.wr_en && !push) overflow <= 1'b1;
    end
  end

`ifdef FIR_SRC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  logic          timeout_err;
  assign bus.timeout_err = timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // pend delays input_ready by one cycle after the pop so in_sample settles first.
  always_ff @(posedge clk_05 or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pend        <= 1'b0;
      in_sample   <= '0;
      last_result <= '0;
      input_ready <= 1'b0;
      sample_done <= 1'b0;
`ifdef FIR_SRC_TIMEOUT_EN
      tmr         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      sample_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            in_sample <= mem[rd_ptr];
            pend      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (pend) begin
            pend        <= 1'b0;
            input_ready <= 1'b1;
`ifdef FIR_SRC_TIMEOUT_EN
            tmr         <= TW'(TIMEOUT - 1);
`endif
          end else if (bus.output_ready) begin
            last_result <= bus.filt_out;
            sample_done <= 1'b1;
            input_ready <= 1'b0;
            state       <= WAIT_REL;
          end
`ifdef FIR_SRC_TIMEOUT_EN
          else if (tmr == '0) begin
            input_ready <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
`endif
        end
        WAIT_REL: begin
          if (!bus.output_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source: vector table for the basic handshake plus
// hand-written sequences for overflow, full-FIFO bypass, long output_ready, reset and timeout.
module tb_fir_sample_source;
  logic clk_05 = 1'b0;
  logic rst    = 1'b0;
  int   nvec   = 0;
  int   nerr   = 0;

  always #5 clk_05 = ~clk_05;

  fir_sample_source_if #(.DATA_W(16), .DEPTH(8)) bus ();

  fir_sample_source #(.DATA_W(16), .DEPTH(8), .TIMEOUT(255)) dut (
    .clk_05 (clk_05),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        ord;
    logic [15:0] filt;
    logic        ir;
    logic [15:0] ins;
    logic        sd;
    logic [3:0]  cnt;
    logic        emp;
    logic [15:0] last;
  } vec_t;

  vec_t tv [12];

  task automatic tick();
    @(posedge clk_05);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.wr_en = 0; bus.wr_data = '0; bus.output_ready = 0; bus.filt_out = '0;
    rst = 0;
    tick(); tick();
    rst = 1;
  endtask

  task automatic write(input logic [15:0] d);
    bus.wr_en = 1; bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic wait_ir(input string name);
    for (int i = 0; i < 20 && !bus.input_ready; i++) tick();
    if (!bus.input_ready) chk({name, "_wait_ir"}, 0, 1);
  endtask

  task automatic serve(input logic [15:0] exp, input logic [15:0] res);
    wait_ir("serve");
    chk("serve_in_sample", bus.in_sample, exp);
    bus.output_ready = 1; bus.filt_out = res;
    tick();
    chk("serve_done", {bus.sample_done, bus.last_result}, {1'b1, res});
    bus.output_ready = 0;
    tick();
  endtask

  initial begin
    int sd_cnt;
    logic saw_ir, saw_sd;

    tv[0]  = '{1'b1, 16'h0051, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'd1, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0051, 1'b0, 4'd0, 1'b1, 16'h0000};
    tv[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0051, 1'b0, 4'd0, 1'b1, 16'h0000};
    tv[3]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0051, 1'b1, 4'd0, 1'b1, 16'h1234};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0051, 1'b0, 4'd0, 1'b1, 16'h1234};
    tv[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0051, 1'b0, 4'd0, 1'b1, 16'h1234};
    tv[6]  = '{1'b1, 16'h000A, 1'b0, 16'h0000, 1'b0, 16'h0051, 1'b0, 4'd1, 1'b0, 16'h1234};
    tv[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 4'd0, 1'b1, 16'h1234};
    tv[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000A, 1'b0, 4'd0, 1'b1, 16'h1234};
    tv[9]  = '{1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'h000A, 1'b1, 4'd0, 1'b1, 16'hFFFE};
    tv[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 4'd0, 1'b1, 16'hFFFE};
    tv[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b0, 4'd0, 1'b1, 16'hFFFE};

    // reset state
    do_reset();
    chk("reset_outputs",
        {bus.input_ready, bus.in_sample, bus.sample_done, bus.count, bus.empty, bus.full,
         bus.last_result, bus.overflow, bus.timeout_err},
        {1'b0, 16'h0, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0});

    // basic handshake vectors
    for (int i = 0; i < 12; i++) begin
      bus.wr_en = tv[i].wr_en; bus.wr_data = tv[i].wr_data;
      bus.output_ready = tv[i].ord; bus.filt_out = tv[i].filt;
      tick();
      nvec++;
      if ({bus.input_ready, bus.in_sample, bus.sample_done, bus.count, bus.empty, bus.last_result} !==
          {tv[i].ir, tv[i].ins, tv[i].sd, tv[i].cnt, tv[i].emp, tv[i].last}) begin
        nerr++;
        $display("FAIL vec%0d: got ir=%0b ins=%h sd=%0b cnt=%0d emp=%0b last=%h, want ir=%0b ins=%h sd=%0b cnt=%0d emp=%0b last=%h",
                 i, bus.input_ready, bus.in_sample, bus.sample_done, bus.count, bus.empty, bus.last_result,
                 tv[i].ir, tv[i].ins, tv[i].sd, tv[i].cnt, tv[i].emp, tv[i].last);
      end
    end
    bus.wr_en = 0; bus.output_ready = 0;

    // overflow: one sample held in SEND, then 9 writes
    do_reset();
    write(16'h0D00); tick(); tick();
    chk("ovf_first_presented", bus.input_ready, 1);
    for (int i = 0; i < 9; i++) write(16'h0100 + 16'(i));
    chk("ovf_state", {bus.full, bus.count, bus.overflow}, {1'b1, 4'd8, 1'b1});
    serve(16'h0D00, 16'h0001);
    for (int i = 0; i < 8; i++) serve(16'h0100 + 16'(i), 16'h0002);
    for (int i = 0; i < 5; i++) tick();
    chk("ovf_ninth_dropped", {bus.input_ready, bus.empty}, {1'b0, 1'b1});

    // full FIFO with write and pop on the same edge
    do_reset();
    write(16'h0D01); tick(); tick();
    for (int i = 0; i < 8; i++) write(16'h0200 + 16'(i));
    chk("full_pre", {bus.full, bus.count, bus.overflow}, {1'b1, 4'd8, 1'b0});
    bus.output_ready = 1; bus.filt_out = 16'h0003; tick();
    bus.output_ready = 0; tick();
    write(16'h0208);
    chk("full_bypass", {bus.full, bus.count, bus.overflow, bus.in_sample}, {1'b1, 4'd8, 1'b0, 16'h0200});
    for (int i = 0; i < 9; i++) serve(16'h0200 + 16'(i), 16'h0300 + 16'(i));
    chk("full_drained", {bus.empty, bus.overflow}, {1'b1, 1'b0});

    // output_ready held 5 cycles
    do_reset();
    write(16'h0A0A); write(16'h0B0B);
    wait_ir("hold");
    chk("hold_first", bus.in_sample, 16'h0A0A);
    bus.output_ready = 1; bus.filt_out = 16'h4444;
    sd_cnt = 0; saw_ir = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.sample_done) sd_cnt++;
      if (bus.input_ready) saw_ir = 1;
    end
    bus.output_ready = 0;
    tick();
    if (bus.sample_done) sd_cnt++;
    chk("hold_ir_fall_edge", bus.input_ready, 0);
    tick();
    chk("hold_ir_plus1", bus.input_ready, 0);
    tick();
    chk("hold_next", {bus.input_ready, bus.in_sample}, {1'b1, 16'h0B0B});
    chk("hold_sd_once", sd_cnt, 1);
    chk("hold_no_ir_during", saw_ir, 0);

    // reset mid-handshake with 3 samples queued
    do_reset();
    for (int i = 0; i < 4; i++) write(16'h0500 + 16'(i));
    wait_ir("rst_mid");
    chk("rst_mid_pre", bus.count, 3);
    #2 rst = 0;
    #1;
    chk("rst_mid_async",
        {bus.empty, bus.input_ready, bus.count, bus.sample_done, bus.in_sample},
        {1'b1, 1'b0, 4'd0, 1'b0, 16'h0});
    tick(); tick();
    rst = 1;
    saw_sd = 0; saw_ir = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.sample_done) saw_sd = 1;
      if (bus.input_ready) saw_ir = 1;
    end
    chk("rst_mid_quiet", {saw_sd, saw_ir, bus.empty}, {1'b0, 1'b0, 1'b1});

`ifdef FIR_SRC_TIMEOUT_EN
    begin
      int n;
      do_reset();
      write(16'h0C00); write(16'h0C01);
      wait_ir("tmo");
      n = 0;
      while (bus.input_ready && n < 400) begin
        tick();
        n++;
      end
      chk("tmo_cycles", n, 255);
      chk("tmo_flags", {bus.timeout_err, bus.sample_done}, {1'b1, 1'b0});
      wait_ir("tmo_next");
      chk("tmo_next_sample", bus.in_sample, 16'h0C01);
    end
`else
    do_reset();
    write(16'h0C00);
    wait_ir("notmo");
    for (int i = 0; i < 300; i++) tick();
    chk("notmo_still_waiting", {bus.input_ready, bus.timeout_err}, {1'b1, 1'b0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
